// File: rtl/mp4_cache_tag_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp4_cache_types (package)
//  Description : Shared widths, FSM state encoding and address-field helpers
//                for the direct-mapped L1 tag/control stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mp4_cache_types;

    localparam int unsigned c_ADDR_WIDTH   = 32;
    localparam int unsigned c_TAG_WIDTH    = 23;
    localparam int unsigned c_IDX_WIDTH    = 4;
    localparam int unsigned c_OFFSET_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_REFETCH   = 3'd4
    } state_t;

    // Tag field: the bits above index and offset.
    function automatic logic [c_TAG_WIDTH-1:0] addr_tag(input logic [c_ADDR_WIDTH-1:0] a);
        return a[c_ADDR_WIDTH-1 -: c_TAG_WIDTH];
    endfunction

    // Set index field: the bits directly above the byte offset.
    function automatic logic [c_IDX_WIDTH-1:0] addr_idx(input logic [c_ADDR_WIDTH-1:0] a);
        return a[c_OFFSET_WIDTH +: c_IDX_WIDTH];
    endfunction

    // Rebuild a line-aligned byte address from tag and index.
    function automatic logic [c_ADDR_WIDTH-1:0] line_addr(input logic [c_TAG_WIDTH-1:0] t,
                                                          input logic [c_IDX_WIDTH-1:0] i);
        return {t, i, {c_OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage : mp4_cache_types
`default_nettype wire

// File: rtl/mp4_cache_tag_ctrl_meta.sv
`default_nettype none
// ============================================================================
//  Module      : mp4_cache_meta
//  Description : Per-set valid and dirty flops with one synchronous
//                set/clear port and a combinational read of the same set.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp4_cache_meta
    import mp4_cache_types::*;
#(
    parameter int unsigned IDX_WIDTH = c_IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_WIDTH-1:0] i_idx,
    input  logic                 i_set_valid,
    input  logic                 i_set_dirty,
    input  logic                 i_clr_dirty,
    output logic                 o_valid,
    output logic                 o_dirty
);

    localparam int unsigned c_SETS = 1 << IDX_WIDTH;

    logic [c_SETS-1:0] r_valid;
    logic [c_SETS-1:0] r_dirty;

    // Valid/dirty update; reset invalidates every set. Set wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_set_valid) begin
                r_valid[i_idx] <= 1'b1;
            end
            if (i_set_dirty) begin
                r_dirty[i_idx] <= 1'b1;
            end else if (i_clr_dirty) begin
                r_dirty[i_idx] <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];

endmodule : mp4_cache_meta
`default_nettype wire

// File: rtl/mp4_cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mp4_cache_tag_ctrl
//  Description : Tag-check and control FSM for a direct-mapped L1 cache.
//                Drives the tag SRAM and data-array strobes, tracks
//                valid/dirty per set and sequences writeback and fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp4_cache_tag_ctrl
    import mp4_cache_types::*;
#(
    parameter int unsigned TAG_WIDTH    = c_TAG_WIDTH,
    parameter int unsigned IDX_WIDTH    = c_IDX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = c_OFFSET_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_address,
    output logic                 cpu_resp,
    output logic                 tag_csb0,
    output logic                 tag_web0,
    output logic [IDX_WIDTH-1:0] tag_addr0,
    output logic [TAG_WIDTH-1:0] tag_din0,
    input  logic [TAG_WIDTH-1:0] tag_dout0,
    output logic                 data_csb0,
    output logic                 data_web0,
    output logic                 data_sel_mem,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_address,
    input  logic                 mem_resp
);

    state_t                 r_state;
    state_t                 w_next;

    logic [TAG_WIDTH-1:0]   r_tag;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic                   r_write;
    logic [TAG_WIDTH-1:0]   r_victim;

    logic                   w_latch_req;
    logic                   w_latch_victim;
    logic                   w_set_valid;
    logic                   w_set_dirty;
    logic                   w_clr_dirty;
    logic                   w_valid;
    logic                   w_dirty;
    logic                   w_hit;

    // All metadata accesses refer to the latched set of the current request.
    mp4_cache_meta #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_meta (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (r_idx),
        .i_set_valid (w_set_valid),
        .i_set_dirty (w_set_dirty),
        .i_clr_dirty (w_clr_dirty),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty)
    );

    assign w_hit = w_valid && (tag_dout0 == r_tag);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request and victim capture; the address is frozen from IDLE exit on.
    always_ff @(posedge clk) begin
        if (w_latch_req) begin
            r_tag   <= addr_tag(cpu_address);
            r_idx   <= addr_idx(cpu_address);
            r_write <= cpu_write;
        end
        if (w_latch_victim) begin
            r_victim <= tag_dout0;
        end
    end

    // Next-state and output decode; reset forces every output idle.
    always_comb begin
        w_next         = r_state;
        cpu_resp       = 1'b0;
        tag_csb0       = 1'b1;
        tag_web0       = 1'b1;
        tag_addr0      = r_idx;
        tag_din0       = r_tag;
        data_csb0      = 1'b1;
        data_web0      = 1'b1;
        data_sel_mem   = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        w_latch_req    = 1'b0;
        w_latch_victim = 1'b0;
        w_set_valid    = 1'b0;
        w_set_dirty    = 1'b0;
        w_clr_dirty    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cpu_read || cpu_write) begin
                    tag_csb0    = 1'b0;
                    tag_addr0   = addr_idx(cpu_address);
                    data_csb0   = 1'b0;
                    w_latch_req = 1'b1;
                    w_next      = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                if (w_hit) begin
                    cpu_resp = 1'b1;
                    if (r_write) begin
                        data_csb0   = 1'b0;
                        data_web0   = 1'b0;
                        w_set_dirty = 1'b1;
                    end
                    w_next = ST_IDLE;
                end else begin
                    w_latch_victim = 1'b1;
                    w_next         = (w_valid && w_dirty) ? ST_WRITEBACK : ST_FILL;
                end
            end

            ST_WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = line_addr(r_victim, r_idx);
                if (mem_resp) begin
                    w_clr_dirty = 1'b1;
                    w_next      = ST_FILL;
                end
            end

            ST_FILL: begin
                mem_read    = 1'b1;
                mem_address = line_addr(r_tag, r_idx);
                if (mem_resp) begin
                    tag_csb0     = 1'b0;
                    tag_web0     = 1'b0;
                    data_csb0    = 1'b0;
                    data_web0    = 1'b0;
                    data_sel_mem = 1'b1;
                    w_set_valid  = 1'b1;
                    w_next       = ST_REFETCH;
                end
            end

            ST_REFETCH: begin
                // Re-read the freshly written tag so COMPARE sees a hit.
                tag_csb0  = 1'b0;
                data_csb0 = 1'b0;
                w_next    = ST_COMPARE;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase

        if (rst) begin
            cpu_resp     = 1'b0;
            tag_csb0     = 1'b1;
            tag_web0     = 1'b1;
            tag_addr0    = '0;
            tag_din0     = '0;
            data_csb0    = 1'b1;
            data_web0    = 1'b1;
            data_sel_mem = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_address  = '0;
        end
    end

endmodule : mp4_cache_tag_ctrl
`default_nettype wire
